// File: rtl/updown_counter_ctrl.sv
// Sweep controller for an external up/down counter: accepts a sweep command,
// loads the counter and steps it up, down or bouncing between lo/hi without wrapping.
module updown_counter_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [WIDTH-1:0]  cmd_lo,
  input  logic [WIDTH-1:0]  cmd_hi,
  input  logic [PASS_W-1:0] cmd_passes,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cnt_count,
  output logic              cnt_load,
  output logic [WIDTH-1:0]  cnt_load_val,
  output logic              cnt_en,
  output logic              cnt_up_down,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_RUN_UP   = 3'd2,
    S_RUN_DOWN = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   lo_q;
  logic [WIDTH-1:0]   hi_q;
  logic [1:0]         mode_q;
  logic [PASS_W-1:0]  pass_q;
  logic [PASS_W-1:0]  pass_d;
  logic               pend_q;
  logic               cnt_load_q;
  logic               done_q;
  logic               accept;
  logic               bad_cmd;
  logic               last_pass;
  logic               err_set;
  logic               abort_hit;

  assign accept    = cmd_valid && cmd_ready;
  assign bad_cmd   = (mode_q == MODE_RSVD) || (lo_q > hi_q);
  // A degenerate range ends on the first endpoint regardless of remaining passes
  assign last_pass = (mode_q != MODE_BOUNCE) || (pass_q == PASS_W'(1)) || (lo_q == hi_q);

  // Abort must cancel a pending load or completion in the very cycle it is raised
  assign cnt_load = cnt_load_q && !abort;
  assign done     = done_q && !abort;

  // Next-state, pass bookkeeping and combinational counter controls
  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    cnt_en      = 1'b0;
    cnt_up_down = 1'b0;
    err_set     = 1'b0;
    abort_hit   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          if (bad_cmd) err_set = 1'b1;
          else         state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d = (mode_q == MODE_DOWN) ? S_RUN_DOWN : S_RUN_UP;
        end
      end
      S_RUN_UP: begin
        cnt_up_down = 1'b1;
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_count != hi_q) begin
          cnt_en = 1'b1;
        end else if (last_pass) begin
          state_d = S_DONE;
        end else begin
          // Turn around on the endpoint without dwelling
          pass_d      = pass_q - PASS_W'(1);
          state_d     = S_RUN_DOWN;
          cnt_en      = 1'b1;
          cnt_up_down = 1'b0;
        end
      end
      S_RUN_DOWN: begin
        cnt_up_down = 1'b0;
        if (abort) begin
          abort_hit = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_count != lo_q) begin
          cnt_en = 1'b1;
        end else if (last_pass) begin
          state_d = S_DONE;
        end else begin
          pass_d      = pass_q - PASS_W'(1);
          state_d     = S_RUN_UP;
          cnt_en      = 1'b1;
          cnt_up_down = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort) abort_hit = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched command and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lo_q         <= '0;
      hi_q         <= '0;
      mode_q       <= MODE_UP;
      pass_q       <= '0;
      pend_q       <= 1'b0;
      cmd_ready    <= 1'b1;
      cnt_load_q   <= 1'b0;
      cnt_load_val <= '0;
      busy         <= 1'b0;
      done_q       <= 1'b0;
      aborted      <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= accept;
      if (accept) begin
        lo_q   <= cmd_lo;
        hi_q   <= cmd_hi;
        mode_q <= cmd_mode;
        pass_q <= (cmd_passes == '0) ? PASS_W'(1) : cmd_passes;
      end else begin
        pass_q <= pass_d;
      end
      cmd_ready  <= (state_d == S_IDLE) && !accept;
      cnt_load_q <= (state_d == S_LOAD);
      if (state_d == S_LOAD) cnt_load_val <= (mode_q == MODE_DOWN) ? hi_q : lo_q;
      busy    <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      aborted <= abort_hit;
      err     <= err_set;
    end
  end

endmodule
